fp32_mul_pipe: RTL

//  Pipelined IEEE-754 single-precision multiplier: the responder on the fp_X/fp_Y/r_mode ->
//  fp_Z/ovrf/udrf multiplier interface. It accepts one operand pair per cycle on a valid/ready

---
 rtl/fp32_mul_pipe.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fp32_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_mul_pipe
//  Description : Three-stage pipelined IEEE-754 single-precision multiplier
//                with a valid/ready handshake on both sides.
//                  S1 unpack/classify, S2 24x24 significand multiply,
//                  S3 normalise/round/pack (registered outputs).
//                Denormal inputs are flushed to signed zero, and underflowed
//                results are flushed to signed zero.
//  Ports       : clk, rst_n (async, active low)
//                in_valid/in_ready, r_mode[2:0], fp_X[31:0], fp_Y[31:0]
//                out_valid/out_ready, fp_Z[31:0], ovrf, udrf
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_mul_pipe #(
    parameter logic [31:0] NAN_CANON = 32'h7FC0_0000,
    parameter bit          FTZ       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  r_mode,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf
);

    localparam logic [2:0] c_rne = 3'b000;
    localparam logic [2:0] c_rtz = 3'b001;
    localparam logic [2:0] c_rdn = 3'b010;
    localparam logic [2:0] c_rup = 3'b011;
    localparam logic [2:0] c_rmm = 3'b100;

    localparam logic [31:0] c_pos_inf = 32'h7F80_0000;
    localparam logic [30:0] c_max_mag = 31'h7F7F_FFFF;

    // The whole pipe moves as one; a bubble in a stage is simply carried along.
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S1 combinational: unpack and classify
    // ------------------------------------------------------------------
    logic [7:0]        w_ex, w_ey;
    logic [22:0]       w_fx, w_fy;
    logic              w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_x_zero, w_y_zero;
    logic signed [9:0] w_exp_sum;
    logic [2:0]        w_mode;

    assign w_ex = fp_X[30:23];
    assign w_ey = fp_Y[30:23];
    assign w_fx = fp_X[22:0];
    assign w_fy = fp_Y[22:0];

    assign w_x_nan  = (w_ex == 8'hFF) && (w_fx != 23'd0);
    assign w_y_nan  = (w_ey == 8'hFF) && (w_fy != 23'd0);
    assign w_x_inf  = (w_ex == 8'hFF) && (w_fx == 23'd0);
    assign w_y_inf  = (w_ey == 8'hFF) && (w_fy == 23'd0);
    // With FTZ cleared only true zeros are zero; denormals are then not
    // normalised correctly, so FTZ=1 is the only meaningful setting.
    assign w_x_zero = (w_ex == 8'd0) && (FTZ || (w_fx == 23'd0));
    assign w_y_zero = (w_ey == 8'd0) && (FTZ || (w_fy == 23'd0));

    assign w_exp_sum = $signed({2'b00, w_ex}) + $signed({2'b00, w_ey}) - 10'sd127;

    // Reserved rounding codes collapse to RNE here so later stages see only five.
    assign w_mode = (r_mode > c_rmm) ? c_rne : r_mode;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic              r_s1_valid, r_s1_sign, r_s1_nan, r_s1_inf, r_s1_zero;
    logic signed [9:0] r_s1_exp;
    logic [23:0]       r_s1_mx, r_s1_my;
    logic [2:0]        r_s1_mode;

    logic              r_s2_valid, r_s2_sign, r_s2_nan, r_s2_inf, r_s2_zero;
    logic signed [9:0] r_s2_exp;
    logic [47:0]       r_s2_prod;
    logic [2:0]        r_s2_mode;

    logic [31:0]       w_z;
    logic              w_ovf, w_udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_exp   <= 10'sd0;
            r_s1_mx    <= 24'd0;
            r_s1_my    <= 24'd0;
            r_s1_mode  <= c_rne;
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_nan   <= 1'b0;
            r_s2_inf   <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_exp   <= 10'sd0;
            r_s2_prod  <= 48'd0;
            r_s2_mode  <= c_rne;
            out_valid  <= 1'b0;
            fp_Z       <= 32'd0;
            ovrf       <= 1'b0;
            udrf       <= 1'b0;
        end else if (w_adv) begin
            // S1
            r_s1_valid <= in_valid;
            r_s1_sign  <= fp_X[31] ^ fp_Y[31];
            // Inf*0 is invalid, so it joins the NaN class up front.
            r_s1_nan   <= w_x_nan || w_y_nan || (w_x_inf && w_y_zero) || (w_x_zero && w_y_inf);
            r_s1_inf   <= w_x_inf || w_y_inf;
            r_s1_zero  <= w_x_zero || w_y_zero;
            r_s1_exp   <= w_exp_sum;
            r_s1_mx    <= {1'b1, w_fx};
            r_s1_my    <= {1'b1, w_fy};
            r_s1_mode  <= w_mode;
            // S2
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_nan   <= r_s1_nan;
            r_s2_inf   <= r_s1_inf;
            r_s2_zero  <= r_s1_zero;
            r_s2_exp   <= r_s1_exp;
            r_s2_prod  <= r_s1_mx * r_s1_my;
            r_s2_mode  <= r_s1_mode;
            // S3 / outputs
            out_valid  <= r_s2_valid;
            fp_Z       <= w_z;
            ovrf       <= w_ovf;
            udrf       <= w_udf;
        end
    end

    // ------------------------------------------------------------------
    // S3 combinational: normalise, round, pack, special cases
    // ------------------------------------------------------------------
    logic              w_norm;
    logic [22:0]       w_mant;
    logic              w_g, w_r, w_s, w_l, w_inc, w_grs;
    logic [23:0]       w_mant_r;
    logic signed [9:0] w_exp_n, w_exp_f;

    always_comb begin
        w_norm = r_s2_prod[47];
        if (w_norm) begin
            w_mant  = r_s2_prod[46:24];
            w_g     = r_s2_prod[23];
            w_r     = r_s2_prod[22];
            w_s     = |r_s2_prod[21:0];
            w_exp_n = r_s2_exp + 10'sd1;
        end else begin
            w_mant  = r_s2_prod[45:23];
            w_g     = r_s2_prod[22];
            w_r     = r_s2_prod[21];
            w_s     = |r_s2_prod[20:0];
            w_exp_n = r_s2_exp;
        end
        w_l   = w_mant[0];
        w_grs = w_g || w_r || w_s;

        case (r_s2_mode)
            c_rtz:   w_inc = 1'b0;
            c_rdn:   w_inc = r_s2_sign && w_grs;
            c_rup:   w_inc = !r_s2_sign && w_grs;
            c_rmm:   w_inc = w_g;
            default: w_inc = w_g && (w_r || w_s || w_l);
        endcase

        // A carry out of the 23-bit fraction leaves the fraction at zero,
        // so only the exponent needs bumping.
        w_mant_r = {1'b0, w_mant} + {23'd0, w_inc};
        w_exp_f  = w_mant_r[23] ? (w_exp_n + 10'sd1) : w_exp_n;

        w_z   = {r_s2_sign, w_exp_f[7:0], w_mant_r[22:0]};
        w_ovf = 1'b0;
        w_udf = 1'b0;

        if (r_s2_nan) begin
            w_z = NAN_CANON;
        end else if (r_s2_inf) begin
            w_z = {r_s2_sign, c_pos_inf[30:0]};
        end else if (r_s2_zero) begin
            w_z = {r_s2_sign, 31'd0};
        end else if (w_exp_f >= 10'sd255) begin
            w_ovf = 1'b1;
            case (r_s2_mode)
                c_rtz:   w_z = {r_s2_sign, c_max_mag};
                c_rup:   w_z = r_s2_sign ? {1'b1, c_max_mag} : c_pos_inf;
                c_rdn:   w_z = r_s2_sign ? {1'b1, c_pos_inf[30:0]} : {1'b0, c_max_mag};
                default: w_z = {r_s2_sign, c_pos_inf[30:0]};
            endcase
        end else if (w_exp_f <= 10'sd0) begin
            w_udf = 1'b1;
            w_z   = {r_s2_sign, 31'd0};
        end
    end

endmodule
`default_nettype wire
